fir_feed_ctrl: RTL and testbench
================================

Name: fir_feed_ctrl

Overview:
Upstream feeder and sequencer for the FIR MAC stage (MacUnit). Accepts 3-bit signed samples over a valid/ready handshake and keeps a 10-tap delay line and a 10-entry coefficient register file. Steps MacUnit through its mul/add/acc enable sequence, then registers its 16-bit result as the filter output. One sample per 4 cycles.

Parameters:
TAPS, 10, number of taps / coefficients
DW, 3, sample width (signed)
CW, 16, coefficient width
OW, 16, MAC result / filter output width

Ports:
iClk  in  1  clock, rising edge
iRsn  in  1  asynchronous active-low reset
iInValid  in  1  sample valid
iInData  in  DW  signed input sample
oInReady  out  1  block can accept a sample
iCoeffWe  in  1  coefficient write strobe
iCoeffAddr  in  4  coefficient index
iCoeffData  in  CW  coefficient value
oCoeffDrop  out  1  one-cycle pulse: write rejected
iClear  in  1  synchronous flush of delay line plus abort
oEnMul  out  1  to MacUnit iEnMul
oEnAdd  out  1  to MacUnit iEnAdd
oEnAcc  out  1  to MacUnit iEnAcc
oDelay  out  TAPS*DW  packed taps to MacUnit iDelay
oCoeff  out  TAPS*CW  packed coefficients to MacUnit iCoeff
iMacResult  in  OW  from MacUnit oMacResult
oFirOut  out  OW  registered filter output
oOutValid  out  1  one-cycle pulse: oFirOut updated

Behaviour:
- Reset (iRsn low, async): state IDLE; all taps and coefficients 0; oFirOut 0; oOutValid, oCoeffDrop and all enables 0. oInReady = 1, decoded from IDLE.
- Packing: tap j at oDelay[TAPS*DW-1-j*DW -: DW]; coeff j at oCoeff[TAPS*CW-1-j*CW -: CW]. Tap 0 is the newest sample.
- FSM states: IDLE, MUL, ADD, ACC. oInReady = (state==IDLE).
- IDLE: if iInValid, accept. Shift the delay line (tap0 <= iInData, tap k <= tap k-1, tap 9 discarded), then go to MUL.
- MUL: oEnMul=1, go to ADD.
- ADD: oEnMul=oEnAdd=1, go to ACC.
- ACC: all three enables 1. At the clock edge, oFirOut <= iMacResult, oOutValid <= 1 for one cycle, go to IDLE.
- Enables are decoded from state: cumulative, never glitching, 0 in IDLE.
- Latency: sample accepted at edge E. oOutValid is high in the cycle after edge E+3. A new sample may be accepted in that same cycle, so throughput is 1 per 4 cycles.
- Coefficient write: applied only if state==IDLE and iCoeffAddr<TAPS.
  - Otherwise the write is dropped, state is unchanged, and oCoeffDrop pulses 1 cycle.
  - A write and a sample accept in the same IDLE cycle both take effect. The new coefficient is used for that sample.
- iClear (sync, any state): all taps <= 0, state <= IDLE, no oOutValid for an aborted computation. oFirOut and coefficients are kept.
  - iClear has priority over a sample accept in the same cycle; that sample is not accepted.
  - A coefficient write in the same cycle is still honoured when in IDLE.
- Reset mid-operation aborts immediately with no output pulse.
- No arithmetic here. The result is taken as-is from MacUnit (16-bit wrap).

Decomposition:
- Package fir_pkg: TAPS, DW, CW, OW; FSM state enum (IDLE, MUL, ADD, ACC, 2-bit); coefficient address width.
- One sub-module, fir_delay_line: TAPS x DW shift register with shift-enable and clear, packed output.
- FSM and coefficient file stay in fir_feed_ctrl.

Test Plan:
- Reset release -> oInReady=1, oDelay=0, oCoeff=0, oFirOut=0, no pulses.
- coeff0=2, others 0; push sample 3 (paired with MacUnit) -> oEnMul, oEnAdd, oEnAcc rise on successive cycles; 4 cycles after accept, oFirOut=16'h0006 with a one-cycle oOutValid.
- coeff0=5; push 3'b111 (-1) -> oFirOut=16'hFFFB. Push 11 samples of 1 with all coeffs 1 -> outputs 1,2,…,10,10; tap 9 saturates the window.
- Coeff write at addr 12, or while in MUL -> oCoeffDrop pulse, oCoeff unchanged. Write addr 9 value 7 in IDLE -> oCoeff[15:0]=7.
- iClear asserted in ADD -> state IDLE next cycle, oDelay=0, no oOutValid, oFirOut holds previous value.
- iInValid held high continuously -> exactly one accept per 4 cycles, oInReady low in MUL/ADD/ACC.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared parameters, state encoding and helpers for the FIR feed controller.
package fir_pkg;

   localparam int TAPS = 10;
   localparam int DW   = 3;
   localparam int CW   = 16;
   localparam int OW   = 16;
   localparam int AW   = 4;

   // Sequencer phases; MacUnit enables accumulate as the state advances.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      ADD  = 2'd2,
      ACC  = 2'd3
   } fir_state_e;

   // A coefficient index is usable only if it names an existing tap.
   function automatic logic coeff_addr_ok(input logic [AW-1:0] addr);
      return addr < AW'(TAPS);
   endfunction

endpackage

// File: rtl/fir_feed_ctrl_if.sv
// Sample handshake, coefficient port and MacUnit link of the FIR feed controller.
interface fir_feed_ctrl_if;
   import fir_pkg::*;

   logic                 iInValid;
   logic [DW-1:0]        iInData;
   logic                 oInReady;
   logic                 iCoeffWe;
   logic [AW-1:0]        iCoeffAddr;
   logic [CW-1:0]        iCoeffData;
   logic                 oCoeffDrop;
   logic                 iClear;
   logic                 oEnMul;
   logic                 oEnAdd;
   logic                 oEnAcc;
   logic [TAPS*DW-1:0]   oDelay;
   logic [TAPS*CW-1:0]   oCoeff;
   logic [OW-1:0]        iMacResult;
   logic [OW-1:0]        oFirOut;
   logic                 oOutValid;

   // Environment side: drives samples, coefficients, clear and the MAC result.
   modport master (
      output iInValid, iInData, iCoeffWe, iCoeffAddr, iCoeffData, iClear, iMacResult,
      input  oInReady, oCoeffDrop, oEnMul, oEnAdd, oEnAcc, oDelay, oCoeff,
             oFirOut, oOutValid
   );

   // Controller side.
   modport slave (
      input  iInValid, iInData, iCoeffWe, iCoeffAddr, iCoeffData, iClear, iMacResult,
      output oInReady, oCoeffDrop, oEnMul, oEnAdd, oEnAcc, oDelay, oCoeff,
             oFirOut, oOutValid
   );

endinterface

// File: rtl/fir_delay_line.sv
// TAPS-deep sample delay line; tap 0 holds the newest sample, clear wins over shift.
module fir_delay_line
   import fir_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                shift_en,
   input  logic                clear,
   input  logic [DW-1:0]       din,
   output logic [TAPS*DW-1:0]  taps
);

   logic [DW-1:0] taps_q [TAPS];
   logic [DW-1:0] taps_d [TAPS];

   // Next tap contents: flush, shift in a new sample, or hold.
   always_comb begin
      taps_d = taps_q;
      if (clear) begin
         for (int j = 0; j < TAPS; j++) taps_d[j] = '0;
      end else if (shift_en) begin
         taps_d[0] = din;
         for (int j = 1; j < TAPS; j++) taps_d[j] = taps_q[j-1];
      end
   end

   // Tap storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int j = 0; j < TAPS; j++) taps_q[j] <= '0;
      end else begin
         taps_q <= taps_d;
      end
   end

   // Pack taps MSB-first so tap 0 sits in the top slice.
   always_comb begin
      taps = '0;
      for (int j = 0; j < TAPS; j++) taps[TAPS*DW-1-j*DW -: DW] = taps_q[j];
   end

endmodule

// File: rtl/fir_feed_ctrl.sv
// FIR feed controller: accepts samples, holds coefficients and steps MacUnit
// through mul/add/acc, registering its result as the filter output.
module fir_feed_ctrl
   import fir_pkg::*;
(
   input  logic           iClk,
   input  logic           iRsn,
   fir_feed_ctrl_if.slave bus
);

   fir_state_e     state_q, state_d;
   logic [CW-1:0]  coeff_q [TAPS];
   logic [CW-1:0]  coeff_d [TAPS];
   logic [OW-1:0]  fir_out_q, fir_out_d;
   logic           out_valid_q, out_valid_d;
   logic           coeff_drop_q, coeff_drop_d;
   logic           en_mul_q, en_mul_d;
   logic           en_add_q, en_add_d;
   logic           en_acc_q, en_acc_d;
   logic           accept;
   logic           coeff_wr_ok;

   assign accept      = (state_q == IDLE) && bus.iInValid && !bus.iClear;
   assign coeff_wr_ok = bus.iCoeffWe && (state_q == IDLE) && coeff_addr_ok(bus.iCoeffAddr);

   fir_delay_line u_delay (
      .clk      (iClk),
      .rst_n    (iRsn),
      .shift_en (accept),
      .clear    (bus.iClear),
      .din      (bus.iInData),
      .taps     (bus.oDelay)
   );

   // Sequencer next state; enables are registered from the next state so
   // they change only on clock edges and never glitch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = MUL;
         MUL:     state_d = ADD;
         ADD:     state_d = ACC;
         ACC:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (bus.iClear) state_d = IDLE;
      en_mul_d = (state_d != IDLE);
      en_add_d = (state_d == ADD) || (state_d == ACC);
      en_acc_d = (state_d == ACC);
   end

   // Coefficient file update; writes outside IDLE or past the last tap bounce.
   always_comb begin
      coeff_d      = coeff_q;
      coeff_drop_d = bus.iCoeffWe && !coeff_wr_ok;
      if (coeff_wr_ok) coeff_d[bus.iCoeffAddr] = bus.iCoeffData;
   end

   // Capture the MAC result at the end of ACC unless the run is being aborted.
   always_comb begin
      out_valid_d = (state_q == ACC) && !bus.iClear;
      fir_out_d   = out_valid_d ? bus.iMacResult : fir_out_q;
   end

   // State, coefficient and output registers.
   always_ff @(posedge iClk or negedge iRsn) begin
      if (!iRsn) begin
         state_q      <= IDLE;
         for (int j = 0; j < TAPS; j++) coeff_q[j] <= '0;
         fir_out_q    <= '0;
         out_valid_q  <= 1'b0;
         coeff_drop_q <= 1'b0;
         en_mul_q     <= 1'b0;
         en_add_q     <= 1'b0;
         en_acc_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         coeff_q      <= coeff_d;
         fir_out_q    <= fir_out_d;
         out_valid_q  <= out_valid_d;
         coeff_drop_q <= coeff_drop_d;
         en_mul_q     <= en_mul_d;
         en_add_q     <= en_add_d;
         en_acc_q     <= en_acc_d;
      end
   end

   // Pack coefficients MSB-first to line up with the tap packing.
   always_comb begin
      bus.oCoeff = '0;
      for (int j = 0; j < TAPS; j++) bus.oCoeff[TAPS*CW-1-j*CW -: CW] = coeff_q[j];
   end

   assign bus.oInReady   = (state_q == IDLE);
   assign bus.oEnMul     = en_mul_q;
   assign bus.oEnAdd     = en_add_q;
   assign bus.oEnAcc     = en_acc_q;
   assign bus.oFirOut    = fir_out_q;
   assign bus.oOutValid  = out_valid_q;
   assign bus.oCoeffDrop = coeff_drop_q;

endmodule

// File: tb/tb_fir_feed_ctrl.sv
// Self-checking bench for fir_feed_ctrl with a behavioural MacUnit and reference model.
module tb_fir_feed_ctrl;
   import fir_pkg::*;

   logic iClk = 1'b0;
   logic iRsn;
   int   checks = 0;
   int   failures = 0;

   always #5 iClk = ~iClk;

   fir_feed_ctrl_if bus();

   fir_feed_ctrl dut (
      .iClk (iClk),
      .iRsn (iRsn),
      .bus  (bus)
   );

   // Behavioural MacUnit: combinational dot product of whatever the controller presents.
   function automatic logic [OW-1:0] macOf(input logic [TAPS*DW-1:0] d, input logic [TAPS*CW-1:0] c);
      int acc;
      logic signed [DW-1:0] t;
      logic [CW-1:0] k;
      acc = 0;
      for (int j = 0; j < TAPS; j++) begin
         t = d[TAPS*DW-1-j*DW -: DW];
         k = c[TAPS*CW-1-j*CW -: CW];
         acc += int'(t) * int'(k);
      end
      return acc[OW-1:0];
   endfunction

   assign bus.iMacResult = macOf(bus.oDelay, bus.oCoeff);

   // Reference model: cycles since accept, tap window and coefficient table.
   int                   mPhase;
   logic signed [DW-1:0] mTap [TAPS];
   logic [CW-1:0]        mCoef [TAPS];
   logic [OW-1:0]        mFirOut;
   logic                 mOutValid;
   logic                 mDrop;
   int                   acceptCount;

   task automatic modelReset();
      mPhase = 0;
      for (int j = 0; j < TAPS; j++) begin
         mTap[j]  = '0;
         mCoef[j] = '0;
      end
      mFirOut   = '0;
      mOutValid = 1'b0;
      mDrop     = 1'b0;
   endtask

   function automatic logic [OW-1:0] modelMac();
      int acc;
      acc = 0;
      for (int j = 0; j < TAPS; j++) acc += int'(mTap[j]) * int'(mCoef[j]);
      return acc[OW-1:0];
   endfunction

   function automatic logic [TAPS*DW-1:0] expDelay();
      logic [TAPS*DW-1:0] v;
      for (int j = 0; j < TAPS; j++) v[TAPS*DW-1-j*DW -: DW] = mTap[j];
      return v;
   endfunction

   function automatic logic [TAPS*CW-1:0] expCoeff();
      logic [TAPS*CW-1:0] v;
      for (int j = 0; j < TAPS; j++) v[TAPS*CW-1-j*CW -: CW] = mCoef[j];
      return v;
   endfunction

   task automatic checkOutput(input string tag, input logic [TAPS*CW-1:0] actual,
                              input logic [TAPS*CW-1:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
      end
   endtask

   task automatic compareAll();
      checkOutput("inReady",   bus.oInReady,   mPhase == 0);
      checkOutput("enMul",     bus.oEnMul,     mPhase >= 1);
      checkOutput("enAdd",     bus.oEnAdd,     mPhase >= 2);
      checkOutput("enAcc",     bus.oEnAcc,     mPhase == 3);
      checkOutput("delay",     bus.oDelay,     expDelay());
      checkOutput("coeff",     bus.oCoeff,     expCoeff());
      checkOutput("firOut",    bus.oFirOut,    mFirOut);
      checkOutput("outValid",  bus.oOutValid,  mOutValid);
      checkOutput("coeffDrop", bus.oCoeffDrop, mDrop);
   endtask

   task automatic applyStimulus(input bit v, input logic [DW-1:0] d, input bit we,
                                input logic [AW-1:0] a, input logic [CW-1:0] cd, input bit clr);
      bus.iInValid   = v;
      bus.iInData    = d;
      bus.iCoeffWe   = we;
      bus.iCoeffAddr = a;
      bus.iCoeffData = cd;
      bus.iClear     = clr;
   endtask

   // Advance one clock: update the model from the current inputs, then compare.
   task automatic stepCycle();
      bit wrOk;
      wrOk = bus.iCoeffWe && (mPhase == 0) && (int'(bus.iCoeffAddr) < TAPS);
      mDrop     = bus.iCoeffWe && !wrOk;
      mOutValid = (mPhase == 3) && !bus.iClear;
      if (mOutValid) mFirOut = modelMac();
      if (wrOk) mCoef[bus.iCoeffAddr] = bus.iCoeffData;
      if (bus.iClear) begin
         for (int j = 0; j < TAPS; j++) mTap[j] = '0;
         mPhase = 0;
      end else if (mPhase == 0 && bus.iInValid) begin
         for (int j = TAPS-1; j > 0; j--) mTap[j] = mTap[j-1];
         mTap[0] = bus.iInData;
         mPhase = 1;
         acceptCount++;
      end else if (mPhase != 0) begin
         mPhase = (mPhase + 1) % 4;
      end
      @(posedge iClk);
      @(negedge iClk);
      compareAll();
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(0, '0, 0, '0, '0, 0);
         stepCycle();
      end
   endtask

   logic [OW-1:0] savedOut;

   initial begin
      iRsn = 1'b0;
      acceptCount = 0;
      applyStimulus(0, '0, 0, '0, '0, 0);
      modelReset();
      #23;
      compareAll();
      @(negedge iClk);
      iRsn = 1'b1;
      compareAll();

      // coeff0 = 2 written together with sample 3; output 6 four cycles later.
      applyStimulus(1, 3'd3, 1, 4'd0, 16'd2, 0);
      stepCycle();
      checkOutput("enMulFirst", {bus.oEnMul, bus.oEnAdd, bus.oEnAcc}, 3'b100);
      idleCycles(1);
      checkOutput("enAddSecond", {bus.oEnMul, bus.oEnAdd, bus.oEnAcc}, 3'b110);
      idleCycles(1);
      checkOutput("enAccThird", {bus.oEnMul, bus.oEnAdd, bus.oEnAcc}, 3'b111);
      idleCycles(1);
      checkOutput("firOutSix", bus.oFirOut, 16'h0006);
      checkOutput("validSix", bus.oOutValid, 1'b1);

      // coeff0 = 5 then sample -1 (tap1 still 3 with coeff1 0).
      applyStimulus(0, '0, 1, 4'd0, 16'd5, 0);
      stepCycle();
      applyStimulus(1, 3'b111, 0, '0, '0, 0);
      stepCycle();
      idleCycles(3);
      checkOutput("firOutNeg", bus.oFirOut, 16'hFFFB);

      // All coefficients 1, flushed window, eleven unit samples.
      applyStimulus(0, '0, 0, '0, '0, 1);
      stepCycle();
      for (int j = 0; j < TAPS; j++) begin
         applyStimulus(0, '0, 1, 4'(j), 16'd1, 0);
         stepCycle();
      end
      for (int k = 1; k <= 11; k++) begin
         applyStimulus(1, 3'd1, 0, '0, '0, 0);
         stepCycle();
         idleCycles(3);
         checkOutput("rampOut", bus.oFirOut, OW'(k > 10 ? 10 : k));
      end

      // Rejected writes: out-of-range address, and any write while busy.
      applyStimulus(0, '0, 1, 4'd12, 16'hABCD, 0);
      stepCycle();
      checkOutput("dropAddr", bus.oCoeffDrop, 1'b1);
      applyStimulus(1, 3'd2, 0, '0, '0, 0);
      stepCycle();
      applyStimulus(0, '0, 1, 4'd3, 16'h1234, 0);
      stepCycle();
      checkOutput("dropBusy", bus.oCoeffDrop, 1'b1);
      idleCycles(3);
      applyStimulus(0, '0, 1, 4'd9, 16'd7, 0);
      stepCycle();
      checkOutput("coeff9", bus.oCoeff[15:0], 16'd7);

      // Clear during ADD aborts the run and keeps the last output.
      savedOut = mFirOut;
      applyStimulus(1, 3'd3, 0, '0, '0, 0);
      stepCycle();
      idleCycles(1);
      applyStimulus(0, '0, 0, '0, '0, 1);
      stepCycle();
      checkOutput("clearDelay", bus.oDelay, '0);
      checkOutput("clearReady", bus.oInReady, 1'b1);
      idleCycles(3);
      checkOutput("clearHold", bus.oFirOut, savedOut);

      // Valid held high: one accept per four cycles.
      acceptCount = 0;
      for (int i = 0; i < 40; i++) begin
         applyStimulus(1, 3'($urandom_range(0, 7)), 0, '0, '0, 0);
         stepCycle();
      end
      checkOutput("acceptRate", 32'(acceptCount), 32'd10);

      // Randomised traffic.
      for (int i = 0; i < 600; i++) begin
         applyStimulus($urandom_range(0, 1), 3'($urandom_range(0, 7)),
                       $urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)),
                       16'($urandom), $urandom_range(0, 19) == 0);
         stepCycle();
      end

      // Asynchronous reset in the middle of a computation.
      applyStimulus(1, 3'd1, 0, '0, '0, 0);
      stepCycle();
      applyStimulus(0, '0, 0, '0, '0, 0);
      #2;
      iRsn = 1'b0;
      modelReset();
      #1;
      compareAll();
      @(negedge iClk);
      iRsn = 1'b1;
      idleCycles(4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
